// File: rtl/alu_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_add_arbiter
// Description : Two requesters share one 16-bit adder. A three-state FSM
//               (IDLE -> CALC -> RESP) grants one requester at a time. When
//               both request together, a round-robin pointer picks the winner.
//               The sum and its flags are registered and held until the
//               consumer accepts them.
// Ports       : clk, rst_n (async, active-low)
//               req0_valid/req0_a/req0_b/req0_ready : requester 0
//               req1_valid/req1_a/req1_b/req1_ready : requester 1
//               rsp_valid/rsp_ready/rsp_id/rsp_sum  : response channel
//               rsp_sign/overflow/zero/parity/carry : result flags
//               sticky_ovf : sticky overflow. It is only live when the macro
//                            ALU_ARB_STICKY_OVF_EN is defined and is
//                            otherwise tied to 0.
// Parameters  : RR_INIT - requester favoured first after reset
// Revision    : 1.0 - initial release
// ============================================================================
module alu_add_arbiter #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        req1_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_sum,
  output logic        rsp_sign,
  output logic        rsp_overflow,
  output logic        rsp_zero,
  output logic        rsp_parity,
  output logic        rsp_carry,
  output logic        sticky_ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_grant0;
  logic        w_grant1;
  logic        r_ptr;        // requester favoured on the next contested grant
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic        r_id;
  logic [16:0] w_sum_full;
  logic        w_ovf;

  logic        r_rsp_valid;
  logic        r_rsp_id;
  logic [15:0] r_rsp_sum;
  logic        r_rsp_sign;
  logic        r_rsp_overflow;
  logic        r_rsp_zero;
  logic        r_rsp_parity;
  logic        r_rsp_carry;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and grant decode. Grants depend only on the current state and
  // the valids, so ready answers in the same cycle as valid.
  always_comb begin
    w_state_nxt = r_state;
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req0_valid && (!req1_valid || !r_ptr)) begin
          w_grant0 = 1'b1;
        end else if (req1_valid) begin
          w_grant1 = 1'b1;
        end
        if (w_grant0 || w_grant1) begin
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: w_state_nxt = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  // The shared adder works only on the captured operands. This keeps the
  // req* inputs out of the combinational path to the rsp_* registers.
  assign w_sum_full = {1'b0, r_a} + {1'b0, r_b};
  assign w_ovf      = (r_a[15] == r_b[15]) && (w_sum_full[15] != r_a[15]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr          <= RR_INIT;
      r_a            <= 16'h0000;
      r_b            <= 16'h0000;
      r_id           <= 1'b0;
      r_rsp_valid    <= 1'b0;
      r_rsp_id       <= 1'b0;
      r_rsp_sum      <= 16'h0000;
      r_rsp_sign     <= 1'b0;
      r_rsp_overflow <= 1'b0;
      r_rsp_zero     <= 1'b0;
      r_rsp_parity   <= 1'b0;
      r_rsp_carry    <= 1'b0;
    end else begin
      if (w_grant0 || w_grant1) begin
        r_a   <= w_grant1 ? req1_a : req0_a;
        r_b   <= w_grant1 ? req1_b : req0_b;
        r_id  <= w_grant1;
        r_ptr <= w_grant0;  // point at the requester that lost this grant
      end
      if (r_state == S_CALC) begin
        r_rsp_valid    <= 1'b1;
        r_rsp_id       <= r_id;
        r_rsp_sum      <= w_sum_full[15:0];
        r_rsp_sign     <= w_sum_full[15];
        r_rsp_overflow <= w_ovf;
        r_rsp_zero     <= (w_sum_full[15:0] == 16'h0000);
        r_rsp_parity   <= ~^w_sum_full[15:0];
        r_rsp_carry    <= w_sum_full[16];
      end else if (r_state == S_RESP && rsp_ready) begin
        r_rsp_valid    <= 1'b0;
      end
    end
  end

  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_rsp_id;
  assign rsp_sum      = r_rsp_sum;
  assign rsp_sign     = r_rsp_sign;
  assign rsp_overflow = r_rsp_overflow;
  assign rsp_zero     = r_rsp_zero;
  assign rsp_parity   = r_rsp_parity;
  assign rsp_carry    = r_rsp_carry;

`ifdef ALU_ARB_STICKY_OVF_EN
  logic r_sticky_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky_ovf <= 1'b0;
    end else if (r_state == S_CALC && w_ovf) begin
      r_sticky_ovf <= 1'b1;
    end
  end

  assign sticky_ovf = r_sticky_ovf;
`else
  assign sticky_ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_add_arbiter
// Description : Self-checking bench for alu_add_arbiter. It uses table-driven
//               single requests, round-robin contention, a response stall
//               and a reset during CALC. A scoreboard queue holds the
//               expected responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_add_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] rsp_sum;
  logic        rsp_sign, rsp_overflow, rsp_zero, rsp_parity, rsp_carry;
  logic        sticky_ovf;

  alu_add_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_sign(rsp_sign), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
    .rsp_parity(rsp_parity), .rsp_carry(rsp_carry), .sticky_ovf(sticky_ovf)
  );

  always #5 clk = ~clk;

  // flags packed as {sign, overflow, zero, parity, carry}
  typedef struct {
    logic [15:0] sum;
    logic [4:0]  flags;
    logic        id;
    int          acc;
  } exp_t;

  typedef struct {
    logic        id;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic [4:0]  flags;
  } vec_t;

  exp_t q[$];
  exp_t nextexp[2];
  vec_t vecs[8];

  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  bit   seen_head = 1'b0;
  bit   mon_busy;
  logic rr_ptr = 1'b0;
  logic model_sticky = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Independent reference: overflow from signed integer range, parity by reduction
  function automatic exp_t model(logic id, logic [15:0] a, logic [15:0] b);
    exp_t        e;
    logic [16:0] s;
    int          si;
    s  = {1'b0, a} + {1'b0, b};
    si = int'($signed(a)) + int'($signed(b));
    e.sum   = s[15:0];
    e.flags = {s[15], (si > 32767 || si < -32768), (s[15:0] == 16'h0000), ~^s[15:0], s[16]};
    e.id    = id;
    e.acc   = 0;
    return e;
  endfunction

  // Monitor / scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    cycle++;
    if (!rst_n) begin
      q.delete();
      seen_head    = 1'b0;
      rr_ptr       = 1'b0;
      model_sticky = 1'b0;
    end else begin
      mon_busy = (q.size() != 0);
      check("ready0_only_with_valid", {31'd0, req0_ready & ~req0_valid}, 0);
      check("ready1_only_with_valid", {31'd0, req1_ready & ~req1_valid}, 0);
      if (mon_busy) begin
        check("ready0_low_busy", {31'd0, req0_ready}, 0);
        check("ready1_low_busy", {31'd0, req1_ready}, 0);
      end else begin
        check("no_spurious_rsp", {31'd0, rsp_valid}, 0);
      end
      if (rsp_valid && mon_busy) begin
        if (!seen_head) begin
          check("latency", cycle - q[0].acc, 2);
          seen_head = 1'b1;
        end
        check("rsp_sum", {16'd0, rsp_sum}, {16'd0, q[0].sum});
        check("rsp_flags", {27'd0, rsp_sign, rsp_overflow, rsp_zero, rsp_parity, rsp_carry},
              {27'd0, q[0].flags});
        check("rsp_id", {31'd0, rsp_id}, {31'd0, q[0].id});
        if (rsp_ready) begin
`ifdef ALU_ARB_STICKY_OVF_EN
          model_sticky = model_sticky | q[0].flags[3];
`endif
          check("sticky_ovf", {31'd0, sticky_ovf}, {31'd0, model_sticky});
          void'(q.pop_front());
          seen_head = 1'b0;
        end
      end
      if (req0_ready || req1_ready) begin
        check("single_grant", {31'd0, req0_ready & req1_ready}, 0);
        if (req0_valid && req1_valid)
          check("rr_grant", {31'd0, req1_ready}, {31'd0, rr_ptr});
        rr_ptr = ~req1_ready;
        begin
          exp_t e;
          e     = nextexp[req1_ready];
          e.acc = cycle;
          q.push_back(e);
        end
      end
    end
  end

  task automatic send(logic id, logic [15:0] a, logic [15:0] b, exp_t e);
    logic got;
    got = 1'b0;
    @(posedge clk) #1;
    nextexp[id] = e;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = id ? req1_ready : req0_ready;
    end
    check("accept", {31'd0, got}, 1);
    @(posedge clk) #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    check("drain", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] gseq [4];
    int         ng;
    exp_t       e;

    vecs[0] = '{1'b0, 16'h0001, 16'h0002, 16'h0003, 5'b00010};
    vecs[1] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 5'b11000};
    vecs[2] = '{1'b1, 16'hFFFF, 16'h0001, 16'h0000, 5'b00111};
    vecs[3] = '{1'b1, 16'h8000, 16'h8000, 16'h0000, 5'b01111};
    vecs[4] = '{1'b0, 16'h1234, 16'h4321, 16'h5555, 5'b00010};
    vecs[5] = '{1'b1, 16'h00FF, 16'h0000, 16'h00FF, 5'b00010};
    vecs[6] = '{1'b0, 16'h0007, 16'h0000, 16'h0007, 5'b00000};
    vecs[7] = '{1'b1, 16'h8001, 16'hFFFF, 16'h8000, 5'b10001};

    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    nextexp[0] = model(1'b0, 16'h0, 16'h0);
    nextexp[1] = model(1'b1, 16'h0, 16'h0);

    // Reset state: IDLE, so req0_ready follows req0_valid
    repeat (2) @(posedge clk);
    #1;
    check("rst_req0_ready", {31'd0, req0_ready}, 1);
    check("rst_req1_ready", {31'd0, req1_ready}, 0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    check("rst_rsp_sum", {16'd0, rsp_sum}, 0);
    check("rst_sticky", {31'd0, sticky_ovf}, 0);
    req0_valid = 1'b0;
    @(posedge clk) #1 rst_n = 1'b1;

    // Table-driven single requests
    for (int i = 0; i < 8; i++) begin
      e = '{vecs[i].sum, vecs[i].flags, vecs[i].id, 0};
      send(vecs[i].id, vecs[i].a, vecs[i].b, e);
    end
    drain();

    // Response stall: hold rsp_ready low while both requesters wait
    rsp_ready = 1'b0;
    send(1'b0, 16'h1111, 16'h2222, model(1'b0, 16'h1111, 16'h2222));
    nextexp[0] = model(1'b0, 16'h0101, 16'h0202);
    nextexp[1] = model(1'b1, 16'h3000, 16'h0400);
    req0_a = 16'h0101; req0_b = 16'h0202; req0_valid = 1'b1;
    req1_a = 16'h3000; req1_b = 16'h0400; req1_valid = 1'b1;
    for (int i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    @(posedge clk) #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("stall_handshake", {31'd0, rsp_valid & rsp_ready}, 1);
    @(negedge clk);
    check("grant_after_hs", {31'd0, req1_ready}, 1);
    @(posedge clk) #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

    // Round robin after a fresh reset: both valid continuously
    @(posedge clk) #1 rst_n = 1'b0;
    @(posedge clk) #1 rst_n = 1'b1;
    nextexp[0] = model(1'b0, 16'h0010, 16'h0020);
    nextexp[1] = model(1'b1, 16'h0F00, 16'h00F0);
    req0_a = 16'h0010; req0_b = 16'h0020; req0_valid = 1'b1;
    req1_a = 16'h0F00; req1_b = 16'h00F0; req1_valid = 1'b1;
    ng = 0;
    for (int i = 0; i < 40 && ng < 4; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        gseq[ng] = {req1_ready, req0_ready};
        ng++;
      end
    end
    @(posedge clk) #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("rr_count", ng, 4);
    for (int i = 0; i < ng; i++)
      check("rr_seq", {30'd0, gseq[i]}, (i % 2 == 0) ? 32'd1 : 32'd2);
    drain();

    // Reset during CALC: outputs return to reset values at once, no response
    send(1'b0, 16'h7FFF, 16'h0001, model(1'b0, 16'h7FFF, 16'h0001));
    drain();
    send(1'b1, 16'h4000, 16'h4000, model(1'b1, 16'h4000, 16'h4000));
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", {31'd0, rsp_valid}, 0);
    check("midrst_rsp_sum", {16'd0, rsp_sum}, 0);
    check("midrst_flags", {27'd0, rsp_sign, rsp_overflow, rsp_zero, rsp_parity, rsp_carry}, 0);
    check("midrst_id", {31'd0, rsp_id}, 0);
    check("midrst_sticky", {31'd0, sticky_ovf}, 0);
    @(posedge clk) #1 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst_no_rsp", {31'd0, rsp_valid}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
